// File: rtl/udp_cmd_pkg.sv
// Shared types and payload layout for the UDP command receiver.
package udp_cmd_pkg;

    typedef enum logic [7:0] {
        OP_START    = 8'h01,
        OP_SET_MASK = 8'h02,
        OP_SET_LEN  = 8'h03
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2,
        EXEC = 2'd3
    } rx_state_t;

    // Payload byte offsets; the index register saturates at BYTE_ARG_LO.
    localparam logic [1:0] BYTE_MAGIC  = 2'd0;
    localparam logic [1:0] BYTE_OP     = 2'd1;
    localparam logic [1:0] BYTE_ARG_HI = 2'd2;
    localparam logic [1:0] BYTE_ARG_LO = 2'd3;

endpackage

// File: rtl/udp_cmd_rx_sat_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    // Counter register with saturation at MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/udp_cmd_rx.sv
// Parses 4-byte UDP command datagrams (magic, opcode, 16-bit argument) and
// drives capture control; malformed or rejected commands are counted.
module udp_cmd_rx
    import udp_cmd_pkg::*;
#(
    parameter logic [15:0] CMD_PORT     = 16'd5000,
    parameter logic [7:0]  MAGIC        = 8'hA5,
    parameter logic [5:0]  DEFAULT_MASK = 6'h3F,
    parameter logic [15:0] DEFAULT_LEN  = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_udp_hdr_valid,
    output logic        s_udp_hdr_ready,
    input  logic [15:0] s_udp_dest_port,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        capture_busy,
    output logic        start_pulse,
    output logic [5:0]  chan_mask,
    output logic [15:0] capture_len,
    output logic [7:0]  good_cnt,
    output logic [7:0]  bad_cnt
);

    rx_state_t   state_r;
    logic [1:0]  idx_r;
    logic        got4_r;
    logic        magic_ok_r;
    logic [7:0]  op_r;
    logic [15:0] arg_r;
    logic        hdr_ready_r;
    logic        tready_r;
    logic        start_pulse_r;
    logic [5:0]  chan_mask_r;
    logic [15:0] capture_len_r;

    logic beat_s;
    logic hdr_hs_s;
    logic recv_ok_s;
    logic recv_reject_s;
    logic exec_ok_s;
    logic good_inc_s;
    logic bad_inc_s;

    assign beat_s   = s_axis_tvalid && tready_r;
    assign hdr_hs_s = s_udp_hdr_valid && hdr_ready_r;

    // The current beat counts as byte3 when the index has just reached it.
    assign recv_ok_s     = (got4_r || (idx_r == BYTE_ARG_LO)) && magic_ok_r && !s_axis_tuser;
    assign recv_reject_s = (state_r == RECV) && beat_s && s_axis_tlast && !recv_ok_s;

    // Command legality check, evaluated while in EXEC.
    always_comb begin
        exec_ok_s = 1'b0;
        case (op_r)
            OP_START:    exec_ok_s = !capture_busy;
            OP_SET_MASK: exec_ok_s = (arg_r[5:0] != 6'd0);
            OP_SET_LEN:  exec_ok_s = (arg_r != 16'd0);
            default:     exec_ok_s = 1'b0;
        endcase
    end

    assign good_inc_s = (state_r == EXEC) && exec_ok_s;
    assign bad_inc_s  = ((state_r == EXEC) && !exec_ok_s) || recv_reject_s;

    // Receive FSM, payload latches and registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= BYTE_MAGIC;
            got4_r        <= 1'b0;
            magic_ok_r    <= 1'b0;
            op_r          <= 8'h00;
            arg_r         <= 16'h0000;
            hdr_ready_r   <= 1'b1;
            tready_r      <= 1'b1;
            start_pulse_r <= 1'b0;
            chan_mask_r   <= DEFAULT_MASK;
            capture_len_r <= DEFAULT_LEN;
        end else begin
            start_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (hdr_hs_s) begin
                        idx_r       <= BYTE_MAGIC;
                        got4_r      <= 1'b0;
                        magic_ok_r  <= 1'b0;
                        hdr_ready_r <= 1'b0;
                        state_r     <= (s_udp_dest_port == CMD_PORT) ? RECV : DROP;
                    end
                end
                RECV: begin
                    if (beat_s) begin
                        case (idx_r)
                            BYTE_MAGIC:  magic_ok_r <= (s_axis_tdata == MAGIC);
                            BYTE_OP:     op_r <= s_axis_tdata;
                            BYTE_ARG_HI: arg_r[15:8] <= s_axis_tdata;
                            default:     arg_r[7:0] <= got4_r ? arg_r[7:0] : s_axis_tdata;
                        endcase
                        idx_r  <= (idx_r == BYTE_ARG_LO) ? idx_r : idx_r + 2'd1;
                        got4_r <= got4_r || (idx_r == BYTE_ARG_LO);
                        if (s_axis_tlast) begin
                            if (recv_ok_s) begin
                                state_r  <= EXEC;
                                tready_r <= 1'b0;
                            end else begin
                                state_r     <= IDLE;
                                hdr_ready_r <= 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (beat_s && s_axis_tlast) begin
                        state_r     <= IDLE;
                        hdr_ready_r <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_ok_s) begin
                        case (op_r)
                            OP_START:    start_pulse_r <= 1'b1;
                            OP_SET_MASK: chan_mask_r <= arg_r[5:0];
                            OP_SET_LEN:  capture_len_r <= arg_r;
                            default:     start_pulse_r <= 1'b0;
                        endcase
                    end
                    state_r     <= IDLE;
                    hdr_ready_r <= 1'b1;
                    tready_r    <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    hdr_ready_r <= 1'b1;
                    tready_r    <= 1'b1;
                end
            endcase
        end
    end

    assign s_udp_hdr_ready = hdr_ready_r;
    assign s_axis_tready   = tready_r;
    assign start_pulse     = start_pulse_r;
    assign chan_mask       = chan_mask_r;
    assign capture_len     = capture_len_r;

    sat_counter #(.WIDTH(8)) u_good_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (good_inc_s),
        .count (good_cnt)
    );

    sat_counter #(.WIDTH(8)) u_bad_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bad_inc_s),
        .count (bad_cnt)
    );

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Directed bench for udp_cmd_rx: vector table plus back-to-back, reset and saturation sequences.
module tb_udp_cmd_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_udp_hdr_valid = 1'b0;
    logic        s_udp_hdr_ready;
    logic [15:0] s_udp_dest_port = 16'd0;
    logic [7:0]  s_axis_tdata = 8'h00;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        capture_busy = 1'b0;
    logic        start_pulse;
    logic [5:0]  chan_mask;
    logic [15:0] capture_len;
    logic [7:0]  good_cnt;
    logic [7:0]  bad_cnt;

    udp_cmd_rx dut (
        .clk             (clk),
        .reset           (reset),
        .s_udp_hdr_valid (s_udp_hdr_valid),
        .s_udp_hdr_ready (s_udp_hdr_ready),
        .s_udp_dest_port (s_udp_dest_port),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .capture_busy    (capture_busy),
        .start_pulse     (start_pulse),
        .chan_mask       (chan_mask),
        .capture_len     (capture_len),
        .good_cnt        (good_cnt),
        .bad_cnt         (bad_cnt)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [15:0] port;
        logic [47:0] data;
        int          n;
        bit          user;
        bit          busy;
        bit          exp_exec;
        logic [5:0]  mask;
        logic [15:0] len;
        logic [7:0]  good;
        logic [7:0]  bad_n1;
        logic [7:0]  bad;
        bit          pulse;
    } vec_t;

    int n_total = 0;
    int n_bad = 0;
    logic tready_n1;
    logic pulse_n1;
    logic [7:0] bad_n1;
    bit mon_en = 1'b0;
    int stall_cnt = 0;

    always @(negedge clk) begin
        if (mon_en && !s_axis_tready) stall_cnt = stall_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_bad = n_bad + 1;
        n_total = n_total + 1;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Called at a negedge; returns at the negedge after the header handshake.
    task automatic send_hdr(input logic [15:0] port);
        int guard = 0;
        s_udp_hdr_valid = 1'b1;
        s_udp_dest_port = port;
        while (!s_udp_hdr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout("hdr_ready");
        @(negedge clk);
        s_udp_hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last, input bit user);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        while (!s_axis_tready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) timeout("tready");
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Returns at the negedge of cycle N+1 (N = tlast handshake cycle).
    task automatic send_dgram(input logic [15:0] port, input logic [47:0] data,
                              input int n, input bit user, input bit busy);
        capture_busy = busy;
        send_hdr(port);
        for (int i = 0; i < n; i++) begin
            send_beat(data[47-8*i -: 8], (i == n-1), user && (i == n-1));
        end
        tready_n1 = s_axis_tready;
        pulse_n1  = start_pulse;
        bad_n1    = bad_cnt;
    endtask

    function automatic vec_t mk(input logic [15:0] port, input logic [47:0] data, input int n,
                                input bit user, input bit busy, input bit ex,
                                input logic [5:0] mask, input logic [15:0] len,
                                input logic [7:0] good, input logic [7:0] bad_n1,
                                input logic [7:0] bad, input bit pulse);
        vec_t v;
        v.port = port; v.data = data; v.n = n; v.user = user; v.busy = busy;
        v.exp_exec = ex; v.mask = mask; v.len = len; v.good = good;
        v.bad_n1 = bad_n1; v.bad = bad; v.pulse = pulse;
        return v;
    endfunction

    vec_t vt[13];

    initial begin
        // Expected values are cumulative from reset: mask 3F, len 0400, counters 0.
        vt[0]  = mk(16'd5000, 48'hA5_02_00_15_00_00, 4, 0, 0, 1, 6'h15, 16'h0400, 8'd1, 8'd0, 8'd0, 1);
        vt[0].pulse = 1'b0;
        vt[1]  = mk(16'd5000, 48'hA5_01_00_00_00_00, 4, 0, 0, 1, 6'h15, 16'h0400, 8'd2, 8'd0, 8'd0, 1);
        vt[2]  = mk(16'd5000, 48'hA5_01_00_00_00_00, 4, 0, 1, 1, 6'h15, 16'h0400, 8'd2, 8'd0, 8'd1, 0);
        vt[3]  = mk(16'd6000, 48'hA5_03_12_34_00_00, 4, 0, 0, 0, 6'h15, 16'h0400, 8'd2, 8'd1, 8'd1, 0);
        vt[4]  = mk(16'd5000, 48'h5A_03_00_10_00_00, 4, 0, 0, 0, 6'h15, 16'h0400, 8'd2, 8'd2, 8'd2, 0);
        vt[5]  = mk(16'd5000, 48'hA5_03_00_00_00_00, 2, 0, 0, 0, 6'h15, 16'h0400, 8'd2, 8'd3, 8'd3, 0);
        vt[6]  = mk(16'd5000, 48'hA5_03_00_00_00_00, 4, 0, 0, 1, 6'h15, 16'h0400, 8'd2, 8'd3, 8'd4, 0);
        vt[7]  = mk(16'd5000, 48'hA5_03_00_10_00_00, 4, 1, 0, 0, 6'h15, 16'h0400, 8'd2, 8'd5, 8'd5, 0);
        vt[8]  = mk(16'd5000, 48'hA5_03_00_10_00_00, 4, 0, 0, 1, 6'h15, 16'h0010, 8'd3, 8'd5, 8'd5, 0);
        vt[9]  = mk(16'd5000, 48'hA5_04_00_01_00_00, 4, 0, 0, 1, 6'h15, 16'h0010, 8'd3, 8'd5, 8'd6, 0);
        vt[10] = mk(16'd5000, 48'hA5_02_00_40_00_00, 4, 0, 0, 1, 6'h15, 16'h0010, 8'd3, 8'd6, 8'd7, 0);
        vt[11] = mk(16'd5000, 48'hA5_00_00_00_00_00, 1, 0, 0, 0, 6'h15, 16'h0010, 8'd3, 8'd8, 8'd8, 0);
        vt[12] = mk(16'd5000, 48'hA5_03_00_80_FF_FF, 6, 0, 0, 1, 6'h15, 16'h0080, 8'd4, 8'd8, 8'd8, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hdr_ready", 32'(s_udp_hdr_ready), 32'd1);
        chk("rst_tready",    32'(s_axis_tready),   32'd1);
        chk("rst_pulse",     32'(start_pulse),     32'd0);
        chk("rst_mask",      32'(chan_mask),       32'h3F);
        chk("rst_len",       32'(capture_len),     32'd1024);
        chk("rst_good",      32'(good_cnt),        32'd0);
        chk("rst_bad",       32'(bad_cnt),         32'd0);

        for (int i = 0; i < 13; i++) begin
            send_dgram(vt[i].port, vt[i].data, vt[i].n, vt[i].user, vt[i].busy);
            chk($sformatf("v%0d_tready_n1", i), 32'(tready_n1), 32'(!vt[i].exp_exec));
            chk($sformatf("v%0d_pulse_n1", i),  32'(pulse_n1),  32'd0);
            chk($sformatf("v%0d_bad_n1", i),    32'(bad_n1),    32'(vt[i].bad_n1));
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(start_pulse), 32'(vt[i].pulse));
            chk($sformatf("v%0d_mask", i),  32'(chan_mask),   32'(vt[i].mask));
            chk($sformatf("v%0d_len", i),   32'(capture_len), 32'(vt[i].len));
            chk($sformatf("v%0d_good", i),  32'(good_cnt),    32'(vt[i].good));
            chk($sformatf("v%0d_bad", i),   32'(bad_cnt),     32'(vt[i].bad));
            @(negedge clk);
            chk($sformatf("v%0d_pulse_after", i), 32'(start_pulse), 32'd0);
        end

        // Back-to-back datagrams: one EXEC stall after each.
        mon_en = 1'b1;
        stall_cnt = 0;
        send_dgram(16'd5000, 48'hA5_03_01_00_FF_FF, 6, 0, 0);
        chk("b2b_first_exec", 32'(tready_n1), 32'd0);
        send_dgram(16'd5000, 48'hA5_02_00_01_00_00, 4, 0, 0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("b2b_stalls", 32'(stall_cnt),   32'd2);
        chk("b2b_len",    32'(capture_len), 32'h0100);
        chk("b2b_mask",   32'(chan_mask),   32'h01);
        chk("b2b_good",   32'(good_cnt),    32'd6);
        chk("b2b_bad",    32'(bad_cnt),     32'd8);

        // Reset after byte1 of a datagram.
        send_hdr(16'd5000);
        send_beat(8'hA5, 1'b0, 1'b0);
        send_beat(8'h03, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_mask", 32'(chan_mask),   32'h3F);
        chk("mid_rst_len",  32'(capture_len), 32'd1024);
        chk("mid_rst_good", 32'(good_cnt),    32'd0);
        chk("mid_rst_bad",  32'(bad_cnt),     32'd0);
        send_beat(8'h00, 1'b0, 1'b0);
        send_beat(8'h20, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_rst_tail_len", 32'(capture_len), 32'd1024);
        chk("mid_rst_tail_bad", 32'(bad_cnt),     32'd0);
        chk("mid_rst_tail_hdr", 32'(s_udp_hdr_ready), 32'd1);
        send_dgram(16'd5000, 48'hA5_02_00_07_00_00, 4, 0, 0);
        @(negedge clk);
        chk("post_rst_mask", 32'(chan_mask), 32'h07);
        chk("post_rst_good", 32'(good_cnt),  32'd1);

        // Saturation of bad_cnt.
        for (int k = 0; k < 300; k++) begin
            send_dgram(16'd5000, 48'h5A_00_00_00_00_00, 1, 0, 0);
        end
        @(negedge clk);
        chk("sat_bad",  32'(bad_cnt),   32'hFF);
        chk("sat_good", 32'(good_cnt),  32'd1);
        chk("sat_mask", 32'(chan_mask), 32'h07);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
